// File: rtl/serial_deserializer_pkg.sv
// Shared constants and output-buffer state encoding for the serial deserializer.
package serial_deserializer_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic {
      StEmpty = 1'b0,
      StFull  = 1'b1
   } state_t;

endpackage

// File: rtl/serial_deserializer_if.sv
// Serial input, consumer handshake and status signals of the serial deserializer.
interface serial_deserializer_if
   import serial_deserializer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);
   localparam int unsigned CW = $clog2(WIDTH);

   logic             d;
   logic             sen;
   logic             ready;
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             overrun;
   logic [CW-1:0]    count;

   modport master (
      output d, sen, ready,
      input  data, valid, overrun, count
   );

   modport slave (
      input  d, sen, ready,
      output data, valid, overrun, count
   );

endinterface

// File: rtl/dff_r.sv
// Single-bit D flip-flop with asynchronous active-high reset.
module dff_r (
   input  logic d,
   input  logic c,
   input  logic rst,
   output logic Q
);

   always_ff @(posedge c or posedge rst) begin
      if (rst) begin
         Q <= 1'b0;
      end else begin
         Q <= d;
      end
   end

endmodule

// File: rtl/serial_deserializer.sv
// Collects WIDTH serial bits (MSB first) into a word and offers it through a
// one-deep valid/ready buffer; words completing while the buffer is blocked are dropped.
module serial_deserializer
   import serial_deserializer_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input logic                  c,
   input logic                  rst,
   serial_deserializer_if.slave bus
);

   localparam int unsigned   CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   // The oldest bit leaves the shift register on the completing edge, so only
   // WIDTH-1 bits ever need to be stored.
   logic [WIDTH-2:0] sreg_q;
   logic [WIDTH-1:0] word;
   logic [WIDTH-1:0] data_q;
   logic [CW-1:0]    count_q;
   logic             complete;
   logic             load;
   logic             valid_q;
   logic             valid_d;
   logic             overrun_q;
   logic             overrun_d;
   state_t           state_q;
   state_t           state_d;

   assign word     = {sreg_q, bus.d};
   assign complete = bus.sen && (count_q == LAST);

   always_ff @(posedge c or posedge rst) begin
      if (rst) begin
         sreg_q  <= '0;
         count_q <= '0;
         data_q  <= '0;
      end else begin
         if (bus.sen) begin
            sreg_q  <= word[WIDTH-2:0];
            count_q <= complete ? '0 : count_q + CW'(1);
         end
         if (load) begin
            data_q <= word;
         end
      end
   end

   // The valid flop doubles as the buffer state register.
   assign state_q = state_t'(valid_q);

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      overrun_d = overrun_q;
      unique case (state_q)
         StEmpty: begin
            if (complete) begin
               state_d = StFull;
               load    = 1'b1;
            end
         end
         StFull: begin
            if (complete) begin
               if (bus.ready) begin
                  load = 1'b1;
               end else begin
                  overrun_d = 1'b1;
               end
            end else if (bus.ready) begin
               state_d = StEmpty;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   assign valid_d = (state_d == StFull);

   dff_r u_valid (
      .d   (valid_d),
      .c   (c),
      .rst (rst),
      .Q   (valid_q)
   );

   dff_r u_overrun (
      .d   (overrun_d),
      .c   (c),
      .rst (rst),
      .Q   (overrun_q)
   );

   assign bus.data    = data_q;
   assign bus.valid   = valid_q;
   assign bus.overrun = overrun_q;
   assign bus.count   = count_q;

endmodule
